// File: rtl/temp_alarm_pkg.sv
// Shared constants, types and the window-sum helper for the temperature alarm.
package temp_alarm_pkg;

    localparam int WINDOW_DEPTH      = 4;
    localparam int ALARM_THRESHOLD_C = 51;
    localparam int KELVIN_OFFSET     = 273;
    localparam int SAMPLE_W          = 7;
    localparam int SUM_W             = 9;

    typedef logic [SAMPLE_W-1:0]          sample_t;
    typedef sample_t [WINDOW_DEPTH-1:0]   window_t;

    // Four 7-bit samples peak at 508, so 9 bits never overflow.
    function automatic logic [SUM_W-1:0] win_sum(input window_t w);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < WINDOW_DEPTH; i++) begin
            s = s + SUM_W'(w[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/sample_window4.sv
// Four-deep sample shift register (entry 0 newest) with async clear; exposes entries and their sum.
// One sample per clock, always accepted; no backpressure.
module sample_window4
    import temp_alarm_pkg::*;
(
    input  logic                saat,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] i_sample,
    output window_t             o_win,
    output logic [SUM_W-1:0]    o_sum
);

    window_t r_win;

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_win <= '0;
        end else begin
            r_win <= {r_win[WINDOW_DEPTH-2:0], i_sample};
        end
    end

    assign o_win = r_win;
    assign o_sum = win_sum(r_win);

endmodule

// File: rtl/temp_alarm.sv
// Moving-average temperature monitor with alarm; outputs are combinational on the window,
// so a sample is reflected right after the edge that captures it. No handshake.
module temp_alarm
    import temp_alarm_pkg::*;
#(
    parameter int C = 0
)
(
    input  logic                saat,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sicaklik,
    output logic [2*C+6:0]      ortalama_sicaklik,
    output logic                alarm_cal
);

    localparam int OUT_W = 2*C + 7;

    window_t             w_win;
    logic [SUM_W-1:0]    w_sum;
    logic [SAMPLE_W-1:0] w_avg_c;

    sample_window4 u_window (
        .saat     (saat),
        .reset    (reset),
        .i_sample (sicaklik),
        .o_win    (w_win),
        .o_sum    (w_sum)
    );

    // Floor divide by the window depth; top SAMPLE_W bits of the sum.
    assign w_avg_c = w_sum[SUM_W-1:2];

    generate
        if (C == 1) begin : g_kelvin
            assign ortalama_sicaklik = OUT_W'(w_avg_c) + OUT_W'(KELVIN_OFFSET);
        end else begin : g_celsius
            assign ortalama_sicaklik = OUT_W'(w_avg_c);
        end
    endgenerate

    // Threshold is always judged in Celsius, whatever the reported scale.
    assign alarm_cal = (w_avg_c >= SAMPLE_W'(ALARM_THRESHOLD_C));

endmodule

// File: tb/tb_temp_alarm.sv
// Randomized scoreboard bench for temp_alarm, Celsius and Kelvin instances side by side.
module tb_temp_alarm;

    typedef struct {
        int c_avg;
        int k_avg;
        int alarm;
    } exp_t;

    logic       saat;
    logic       reset;
    logic [6:0] sicaklik;
    logic [6:0] avg_c0;
    logic [8:0] avg_k;
    logic       alarm_c0;
    logic       alarm_k;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];
    int   win[$];

    temp_alarm #(.C(0)) dut_c (
        .saat              (saat),
        .reset             (reset),
        .sicaklik          (sicaklik),
        .ortalama_sicaklik (avg_c0),
        .alarm_cal         (alarm_c0)
    );

    temp_alarm #(.C(1)) dut_k (
        .saat              (saat),
        .reset             (reset),
        .sicaklik          (sicaklik),
        .ortalama_sicaklik (avg_k),
        .alarm_cal         (alarm_k)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: average of the last four samples, zeros standing in after reset.
    function automatic exp_t model_expect();
        exp_t e;
        int   s;
        s = 0;
        foreach (win[i]) s += win[i];
        e.c_avg = s / 4;
        e.k_avg = e.c_avg + 273;
        e.alarm = (e.c_avg >= 51) ? 1 : 0;
        return e;
    endfunction

    task automatic model_clear();
        win = '{0, 0, 0, 0};
    endtask

    task automatic send(input int s);
        @(negedge saat);
        reset    = 1'b0;
        sicaklik = 7'(s);
        win.push_front(s);
        void'(win.pop_back());
        exp_q.push_back(model_expect());
    endtask

    // Reset raised between edges with a nonzero input present; it must clear at once
    // and still win at the following edge.
    task automatic do_reset();
        @(negedge saat);
        sicaklik = 7'($urandom_range(1, 127));
        reset    = 1'b1;
        #1;
        chk("async_rst_c_avg", int'(avg_c0), 0);
        chk("async_rst_c_alarm", int'(alarm_c0), 0);
        chk("async_rst_k_avg", int'(avg_k), 273);
        chk("async_rst_k_alarm", int'(alarm_k), 0);
        model_clear();
        exp_q.push_back(model_expect());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge saat);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("c_avg", int'(avg_c0), e.c_avg);
                chk("c_alarm", int'(alarm_c0), e.alarm);
                chk("k_avg", int'(avg_k), e.k_avg);
                chk("k_alarm", int'(alarm_k), e.alarm);
            end
        end
    end

    initial begin : stimulus
        int plan[];
        int budget;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        sicaklik    = 7'd0;
        model_clear();
        #2;
        chk("init_rst_c_avg", int'(avg_c0), 0);
        chk("init_rst_c_alarm", int'(alarm_c0), 0);
        chk("init_rst_k_avg", int'(avg_k), 273);
        chk("init_rst_k_alarm", int'(alarm_k), 0);

        // -1 entries request a reset; the rest are samples.
        plan = '{32, 45, 39, 48, 70, 55, 0,
                 -1, 15, 88, 43, 67, 12, 10, 12,
                 -1, 127, 125, 123, 120, 124, 126, 64, 32, 0, 0, 0, 0,
                 51, 51, 51, 51, 50, 127, 127, 127, 127,
                 -1, 127, 127, 127, 127, 126, 127, 127, 127};
        foreach (plan[i]) begin
            if (plan[i] < 0) do_reset();
            else send(plan[i]);
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 2) == 0) begin
                send($urandom_range(90, 127));
            end else begin
                send($urandom_range(0, 127));
            end
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge saat);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
